my_inner_prod_core: RTL and testbench

//   Real-time datapath that consumes the 4-element input vector stream and produces its inner

---
 rtl/my_inner_prod_pkg.sv | 13 +
 rtl/my_verif_params_pkg.sv | 6 +
 rtl/my_valid_pipe.sv | 19 +
 rtl/my_inner_prod_core.sv | 87 ++++++++
 tb/tb_my_inner_prod_core.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/my_inner_prod_pkg.sv
// Shared constants and types for the inner-product core.
package my_inner_prod_pkg;

    import my_verif_params_pkg::*;

    localparam int DATA_W  = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int N_ELEM  = 4;
    localparam int LATENCY = 3;

    typedef logic [DATA_W-1:0] elem_t;
    typedef elem_t [N_ELEM-1:0] vec_t;

endpackage : my_inner_prod_pkg

// File: rtl/my_verif_params_pkg.sv
// Verification-wide parameters shared by the real-time blocks and the register interface.
package my_verif_params_pkg;

    localparam int AXI4_LITE_DATA_BIT_WIDTH = 32;

endpackage : my_verif_params_pkg

// File: rtl/my_valid_pipe.sv
// Valid shift register with synchronous reset; bit k is the valid of pipeline stage k+1.
module my_valid_pipe #(
    parameter int DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_sync_rst,
    input  logic             i_valid,
    output logic [DEPTH-1:0] o_valid_pipe
);

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            o_valid_pipe <= '0;
        end else begin
            o_valid_pipe <= (o_valid_pipe << 1) | DEPTH'(i_valid);
        end
    end

endmodule : my_valid_pipe

// File: rtl/my_inner_prod_core.sv
// Three-stage pipelined inner product of a 4-element input vector with programmable coefficients,
// plus a saturating count of emitted results.
module my_inner_prod_core #(
    parameter int DATA_W = my_inner_prod_pkg::DATA_W,
    parameter int N_ELEM = my_inner_prod_pkg::N_ELEM
) (
    input  logic                           i_clk,
    input  logic                           i_sync_rst,
    input  logic [N_ELEM-1:0][DATA_W-1:0]  i_input_vec,
    input  logic                           i_input_vec_valid,
    input  logic [N_ELEM-1:0][DATA_W-1:0]  i_coef_vec,
    input  logic                           i_coef_load,
    input  logic                           i_cnt_clr,
    output logic [DATA_W-1:0]              o_inner_prod,
    output logic                           o_inner_prod_valid,
    output logic [DATA_W-1:0]              o_sample_cnt
);

    import my_inner_prod_pkg::*;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t [N_ELEM-1:0] word_vec_t;

    word_vec_t          coef;
    word_vec_t          prod;
    word_t              psum0;
    word_t              psum1;
    word_t              result;
    word_t              sample_cnt;
    logic [LATENCY-1:0] stage_valid;

    my_valid_pipe #(
        .DEPTH        (LATENCY)
    ) u_valid_pipe (
        .i_clk        (i_clk),
        .i_sync_rst   (i_sync_rst),
        .i_valid      (i_input_vec_valid),
        .o_valid_pipe (stage_valid)
    );

    // Coefs and products share an edge, so a sample accepted alongside a load sees the old coefs.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            coef <= '0;
            prod <= '0;
        end else begin
            if (i_coef_load) begin
                coef <= i_coef_vec;
            end
            if (i_input_vec_valid) begin
                for (int k = 0; k < N_ELEM; k++) begin
                    prod[k] <= i_input_vec[k] * coef[k];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            psum0  <= '0;
            psum1  <= '0;
            result <= '0;
        end else begin
            if (stage_valid[0]) begin
                psum0 <= prod[0] + prod[1];
                psum1 <= prod[2] + prod[3];
            end
            if (stage_valid[1]) begin
                result <= psum0 + psum1;
            end
        end
    end

    // Clear wins over a concurrent increment; the count sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst || i_cnt_clr) begin
            sample_cnt <= '0;
        end else if (stage_valid[LATENCY-1] && (sample_cnt != '1)) begin
            sample_cnt <= sample_cnt + 1'b1;
        end
    end

    assign o_inner_prod       = result;
    assign o_inner_prod_valid = stage_valid[LATENCY-1];
    assign o_sample_cnt       = sample_cnt;

endmodule : my_inner_prod_core

// File: tb/tb_my_inner_prod_core.sv
// Directed scoreboard bench for my_inner_prod_core, plus a narrow instance for counter saturation.
module tb_my_inner_prod_core;

    import my_inner_prod_pkg::*;

    localparam int NW = 4;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    vec_t        in_vec = '0;
    logic        in_valid = 1'b0;
    vec_t        coef_vec = '0;
    logic        coef_load = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] prod_out;
    logic        prod_valid;
    logic [31:0] cnt_out;

    logic [3:0][NW-1:0] n_vec = '0;
    logic               n_valid = 1'b0;
    logic [3:0][NW-1:0] n_coef = '0;
    logic               n_load = 1'b0;
    logic               n_clr = 1'b0;
    logic [NW-1:0]      n_prod;
    logic               n_pvalid;
    logic [NW-1:0]      n_cnt;

    int          tests = 0;
    int          fails = 0;
    int          cycle_no = 0;
    exp_t        sb[$];
    vec_t        m_coef = '0;
    logic [31:0] m_cnt = '0;
    logic [31:0] m_last = '0;
    logic        exp_valid = 1'b0;
    logic        exp_valid_prev = 1'b0;

    always #5 clk = ~clk;

    my_inner_prod_core dut (
        .i_clk              (clk),
        .i_sync_rst         (rst),
        .i_input_vec        (in_vec),
        .i_input_vec_valid  (in_valid),
        .i_coef_vec         (coef_vec),
        .i_coef_load        (coef_load),
        .i_cnt_clr          (cnt_clr),
        .o_inner_prod       (prod_out),
        .o_inner_prod_valid (prod_valid),
        .o_sample_cnt       (cnt_out)
    );

    my_inner_prod_core #(
        .DATA_W             (NW),
        .N_ELEM             (4)
    ) dut_narrow (
        .i_clk              (clk),
        .i_sync_rst         (rst),
        .i_input_vec        (n_vec),
        .i_input_vec_valid  (n_valid),
        .i_coef_vec         (n_coef),
        .i_coef_load        (n_load),
        .i_cnt_clr          (n_clr),
        .o_inner_prod       (n_prod),
        .o_inner_prod_valid (n_pvalid),
        .o_sample_cnt       (n_cnt)
    );

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
        vec_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        v[3] = d;
        return v;
    endfunction

    function automatic logic [31:0] dot(input vec_t v, input vec_t c);
        logic [31:0] acc;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            acc = acc + v[k] * c[k];
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, update the model, check after the next one.
    task automatic applyStimulus(input logic r, input logic vld, input vec_t v,
                                 input logic ld, input vec_t cv, input logic clr);
        exp_t e;
        rst       = r;
        in_valid  = vld;
        in_vec    = v;
        coef_load = ld;
        coef_vec  = cv;
        cnt_clr   = clr;
        if (r) begin
            sb.delete();
            m_coef = '0;
        end else begin
            if (vld) begin
                e.val = dot(v, m_coef);
                e.cyc = cycle_no;
                sb.push_back(e);
            end
            if (ld) begin
                m_coef = cv;
            end
        end
        @(negedge clk);
        cycle_no++;
        if (r) begin
            m_cnt  = '0;
            m_last = '0;
        end else if (clr) begin
            m_cnt = '0;
        end else if (exp_valid_prev && (m_cnt != 32'hFFFF_FFFF)) begin
            m_cnt = m_cnt + 1;
        end
        exp_valid = (sb.size() > 0) && (sb[0].cyc + LATENCY == cycle_no);
        checkOutput("valid", {31'b0, prod_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
            m_last = sb[0].val;
            void'(sb.pop_front());
        end
        checkOutput("inner_prod", prod_out, m_last);
        checkOutput("sample_cnt", cnt_out, m_cnt);
        exp_valid_prev = exp_valid;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        end
    endtask

    initial begin
        // Reset held with valid asserted, then quiet cycles after release
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, mk(1, 2, 3, 4), 1'b0, '0, 1'b0);
        end
        idle(3);

        // Basic single sample
        applyStimulus(1'b0, 1'b0, '0, 1'b1, mk(1, 2, 3, 4), 1'b0);
        applyStimulus(1'b0, 1'b1, mk(10, 20, 30, 40), 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("basic_valid", {31'b0, prod_valid}, 32'd1);
        checkOutput("basic_value", prod_out, 32'd300);
        idle(1);
        checkOutput("basic_cnt", cnt_out, 32'd1);
        idle(2);

        // Back-to-back with wrapping products
        applyStimulus(1'b0, 1'b0, '0, 1'b1, mk(32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                               32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, mk(1, 1, 1, 1), 1'b0, '0, 1'b0);
        end
        idle(4);
        checkOutput("tput_value", prod_out, 32'hFFFF_FFFC);
        checkOutput("tput_cnt", cnt_out, 32'd8);

        // Coefficient switch mid-stream
        applyStimulus(1'b0, 1'b0, '0, 1'b1, mk(1, 1, 1, 1), 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b1, mk(1, 2, 3, 4), (i == 3), mk(2, 2, 2, 2), 1'b0);
        end
        idle(4);
        checkOutput("coef_switch_last", prod_out, 32'd20);

        // Mid-operation reset discards in-flight samples and clears coefs
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, mk(7, 7, 7, 7), 1'b0, '0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, mk(5, 6, 7, 8), 1'b0, '0, 1'b0);
        idle(2);
        checkOutput("post_rst_valid", {31'b0, prod_valid}, 32'd1);
        checkOutput("post_rst_value", prod_out, 32'd0);
        idle(2);

        // Clear concurrent with a result valid
        applyStimulus(1'b0, 1'b0, '0, 1'b1, mk(1, 0, 0, 0), 1'b0);
        applyStimulus(1'b0, 1'b1, mk(9, 0, 0, 0), 1'b0, '0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        checkOutput("clr_vs_valid_cnt", cnt_out, 32'd0);
        idle(1);

        // Saturation on the narrow instance: 20 results into a 4-bit counter
        n_coef = {4'hF, 4'hF, 4'hF, 4'hF};
        n_vec  = {4'h1, 4'h1, 4'h1, 4'h1};
        n_load = 1'b1;
        idle(1);
        n_load  = 1'b0;
        n_valid = 1'b1;
        idle(20);
        n_valid = 1'b0;
        idle(4);
        checkOutput("narrow_sat_cnt", {28'b0, n_cnt}, 32'hF);
        checkOutput("narrow_value", {28'b0, n_prod}, 32'hC);
        n_valid = 1'b1;
        idle(1);
        n_valid = 1'b0;
        idle(2);
        checkOutput("narrow_valid", {31'b0, n_pvalid}, 32'd1);
        checkOutput("narrow_hold_cnt", {28'b0, n_cnt}, 32'hF);
        n_clr = 1'b1;
        idle(1);
        n_clr = 1'b0;
        checkOutput("narrow_clr_cnt", {28'b0, n_cnt}, 32'h0);
        idle(1);
        checkOutput("narrow_clr_stay", {28'b0, n_cnt}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_my_inner_prod_core
